i_fab_deser: RTL and testbench
==============================

# i_fab_deser

Periphery-to-fabric input deserializer. Samples a single-bit serial stream arriving from the I/O periphery on every `CLK` edge. Assembles the bits LSB-first into `WIDTH`-bit words and hands each word to fabric logic through a one-deep valid/ready holding register. An optional bitslip control realigns the word boundary. Sits on the input path as the receiving counterpart of the fabric-to-periphery output buffer.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 3..10; out of range → `$fatal` at elaboration (guarded by `ifndef SYNTHESIS`)

Ports:
- CLK  input  1  sampling and fabric clock; all state on rising edge
- RST  input  1  asynchronous, active-low reset
- D  input  1  serial data bit from periphery
- EN  input  1  sample enable; low freezes shifter and bit counter
- BITSLIP  input  1  boundary realign request; rising edge acts (functional only with `I_FAB_DESER_BITSLIP_EN`)
- DATA_READY  input  1  fabric accepts `Q` this cycle
- Q  output  WIDTH  deserialized word; first received bit in `Q[0]`
- DATA_VALID  output  1  `Q` holds an unconsumed word
- OVERFLOW  output  1  sticky: a completed word was dropped

## Operation
- Reset (RST=0, async): shift register, bit counter `cnt`, bitslip edge register, `Q`, `DATA_VALID`, `OVERFLOW` all 0.
- Shifter: when EN=1, `sr <= {D, sr[WIDTH-1:1]}` every cycle.
- Counter `cnt` runs 0..WIDTH-1. When EN=1 and no slip, it increments and wraps at WIDTH-1 → 0.
- Word complete: EN=1, `cnt==WIDTH-1`, no slip this cycle. Completed word is `{D, sr[WIDTH-1:1]}`.
- Bitslip (macro defined):
  - Slip = `BITSLIP & ~bitslip_q` and EN=1; `bitslip_q` registers `BITSLIP` every cycle, regardless of EN.
  - Slip holds `cnt` for one cycle. The bit is still shifted in, so the boundary moves one bit later.
  - Slip at `cnt==WIDTH-1` suppresses completion that cycle; the word completes on the next enabled cycle.
  - Slip edge while EN=0 is discarded.
  - Held-high `BITSLIP` produces exactly one slip.
- Output register, on word complete:
  - If `DATA_VALID==0` or `DATA_READY==1`: `Q <=` word, `DATA_VALID <= 1`.
  - Otherwise: word is dropped, `Q` is unchanged, `OVERFLOW <= 1`.
- No completion and `DATA_VALID & DATA_READY`: `DATA_VALID <= 0`; `Q` holds its last value.
- `OVERFLOW` clears only on reset.
- `DATA_READY` while `DATA_VALID==0` has no effect.
- EN=0: shifter, `cnt` and slip are frozen. The output handshake continues to operate.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Word latency: bit sampled at enabled edge k is the first bit → `Q`/`DATA_VALID` update at edge k+WIDTH-1, visible after it.
- Steady state with EN=1 held: one word per WIDTH cycles; `DATA_VALID` pulses for 1 cycle if `DATA_READY`=1.
- Back-to-back throughput needs no stall: a word completing while the previous one is being accepted (`DATA_READY=1`) replaces it with `DATA_VALID` staying 1.
- Reset deassertion: first enabled edge after release samples bit 0 of word 0.

## Configuration
- `I_FAB_DESER_BITSLIP_EN` defined: bitslip logic present as described.
- Not defined: `BITSLIP` port is present but ignored. No edge register is built. The boundary is fixed by reset and EN only.

## Test plan
- WIDTH=4, reset, EN=1, DATA_READY=1, D serial 1,0,1,1 → after 4th edge `Q=4'b1101`, DATA_VALID high for 1 cycle.
- Continuous stream 1,0,1,1,0,0,1,0 → `Q=4'hD` then `Q=4'h4`, 4 cycles apart; OVERFLOW=0.
- DATA_READY=0 for 2 words → first word held in `Q`, second dropped, OVERFLOW=1. Then DATA_READY=1 → DATA_VALID falls next edge; OVERFLOW stays 1 until RST=0.
- Macro defined, stream repeating 0,0,0,1: aligned reads `Q=4'h8`. One BITSLIP rising edge → next word delayed one cycle, subsequent words `Q=4'h4`. BITSLIP held high → only one slip.
- EN=0 for 3 cycles mid-word (after 2 bits) → no change to counter; word completes 2 enabled cycles after EN returns, bits correct.
- RST asserted mid-word (cnt=2, DATA_VALID=1) → all outputs 0 immediately (async). Next word assembles from fresh bit 0.

Source files
------------

// File: rtl/i_fab_deser.sv
// Periphery-to-fabric input deserializer: LSB-first serial-to-WIDTH word with a one-deep valid/ready output.
// Optional bitslip realignment is built only when I_FAB_DESER_BITSLIP_EN is defined.
module i_fab_deser #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             EN,
    input  logic             BITSLIP,
    input  logic             DATA_READY,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             OVERFLOW
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifndef SYNTHESIS
    if (WIDTH < 3 || WIDTH > 10) begin : g_width_check
        $fatal(1, "i_fab_deser: WIDTH=%0d outside legal range 3..10", WIDTH);
    end
`endif

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic             slip;
    logic             complete;

`ifdef I_FAB_DESER_BITSLIP_EN
    logic bitslip_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) bitslip_q <= 1'b0;
        else      bitslip_q <= BITSLIP;
    end

    // A slip only counts on an enabled cycle; an edge seen while EN=0 is lost.
    assign slip = EN & BITSLIP & ~bitslip_q;
`else
    logic unused_bitslip;
    assign unused_bitslip = BITSLIP;
    assign slip           = 1'b0;
`endif

    assign word     = {D, sr[WIDTH-1:1]};
    assign complete = EN & ~slip & (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr  <= '0;
            cnt <= '0;
        end else if (EN) begin
            sr <= word;
            if (!slip) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q          <= '0;
            DATA_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else if (complete) begin
            if (!DATA_VALID || DATA_READY) begin
                Q          <= word;
                DATA_VALID <= 1'b1;
            end else begin
                OVERFLOW <= 1'b1;
            end
        end else if (DATA_VALID && DATA_READY) begin
            DATA_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i_fab_deser.sv
// Self-checking bench for i_fab_deser: directed scenarios plus random stimulus against a bit-history model.
// Bitslip scenarios run only when I_FAB_DESER_BITSLIP_EN is defined.
module tb_i_fab_deser;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         D = 1'b0;
    logic         EN = 1'b0;
    logic         BITSLIP = 1'b0;
    logic         DATA_READY = 1'b0;
    logic [W-1:0] Q;
    logic         DATA_VALID;
    logic         OVERFLOW;

    i_fab_deser #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .D         (D),
        .EN        (EN),
        .BITSLIP   (BITSLIP),
        .DATA_READY(DATA_READY),
        .Q         (Q),
        .DATA_VALID(DATA_VALID),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a history of every enabled bit, and a count of bits that advanced the boundary.
    bit          hist[$];
    int unsigned counted;
    bit          bs_prev;
    bit [W-1:0]  exp_q;
    bit          exp_valid;
    bit          exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        counted   = 0;
        bs_prev   = 1'b0;
        exp_q     = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
    endfunction

    function automatic void model_edge(input bit d, input bit en, input bit bs, input bit rdy);
        bit         slip;
        bit         done;
        bit [W-1:0] w;
        slip = 1'b0;
        done = 1'b0;
`ifdef I_FAB_DESER_BITSLIP_EN
        slip = en && bs && !bs_prev;
`endif
        bs_prev = bs;
        if (en) begin
            hist.push_back(d);
            if (hist.size() > W) void'(hist.pop_front());
            if (!slip) begin
                counted++;
                done = (counted % W) == 0;
            end
        end
        if (done) begin
            w = '0;
            for (int i = 0; i < W; i++) w[i] = hist[hist.size() - W + i];
            if (!exp_valid || rdy) begin
                exp_q     = w;
                exp_valid = 1'b1;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
    endfunction

    task automatic cycle(input bit d, input bit en, input bit bs, input bit rdy);
        D          = d;
        EN         = en;
        BITSLIP    = bs;
        DATA_READY = rdy;
        @(posedge CLK);
        model_edge(d, en, bs, rdy);
        #1;
        check("q", 32'(Q), 32'(exp_q));
        check("valid", 32'(DATA_VALID), 32'(exp_valid));
        check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b0;
        #1;
        check("rst_q", 32'(Q), 32'h0);
        check("rst_valid", 32'(DATA_VALID), 32'h0);
        check("rst_overflow", 32'(OVERFLOW), 32'h0);
        model_reset();
        @(posedge CLK);
        #2;
        RST = 1'b1;
    endtask

    initial begin
        bit seq1[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        model_reset();
        @(posedge CLK);
        #1;
        check("reset_q", 32'(Q), 32'h0);
        check("reset_valid", 32'(DATA_VALID), 32'h0);
        check("reset_overflow", 32'(OVERFLOW), 32'h0);
        RST = 1'b1;

        // Continuous stream: 0xD then 0x4, each valid for one cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(seq1[i], 1'b1, 1'b0, 1'b1);
            if (i == 3) begin
                check("tp_word0", 32'(Q), 32'hD);
                check("tp_valid0", 32'(DATA_VALID), 32'h1);
            end
            if (i == 4) check("tp_valid_pulse", 32'(DATA_VALID), 32'h0);
            if (i == 7) check("tp_word1", 32'(Q), 32'h4);
        end
        check("tp_no_ovf", 32'(OVERFLOW), 32'h0);

        // Two words with DATA_READY low: first held, second dropped.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(seq1[i], 1'b1, 1'b0, 1'b0);
        check("ovf_held_q", 32'(Q), 32'hD);
        check("ovf_set", 32'(OVERFLOW), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_valid_fall", 32'(DATA_VALID), 32'h0);
        check("ovf_sticky", 32'(OVERFLOW), 32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // EN low mid-word freezes the boundary.
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("en_gap_not_yet", 32'(DATA_VALID), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("en_gap_word", 32'(Q), 32'h6);
        check("en_gap_valid", 32'(DATA_VALID), 32'h1);

        // Async reset mid-word with a valid word pending.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(seq1[i], 1'b1, 1'b0, 1'b1);
        check("post_rst_word", 32'(Q), 32'hD);

`ifdef I_FAB_DESER_BITSLIP_EN
        // Repeating 0,0,0,1: aligned 0x8; one slip (BITSLIP held) moves it to 0x4.
        do_reset();
        for (int i = 0; i < 12; i++) cycle(bit'(i % 4 == 3), 1'b1, 1'b0, 1'b1);
        check("slip_aligned", 32'(Q), 32'h8);
        for (int i = 12; i < 40; i++) cycle(bit'(i % 4 == 3), 1'b1, 1'b1, 1'b1);
        check("slip_once", 32'(Q), 32'h4);
        for (int i = 40; i < 48; i++) cycle(bit'(i % 4 == 3), 1'b1, 1'b0, 1'b1);
        check("slip_stays", 32'(Q), 32'h4);
        // Rising edge while EN=0 is discarded.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 48; i < 56; i++) cycle(bit'(i % 4 == 3), 1'b1, 1'b1, 1'b1);
        check("slip_en_low", 32'(Q), 32'h4);
`endif

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(1)), bit'($urandom_range(7) != 0),
                  bit'($urandom_range(5) == 0), bit'($urandom_range(3) != 0));
            if (i % 700 == 699) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
